// File: rtl/input_ctrl_pkg.sv
// input_ctrl_pkg
//   Shared definitions for the input value controller: the scan FSM state
//   encoding and the default address/data/depth constants.
package input_ctrl_pkg;

  localparam int DEF_INPUT_NEURON_NUM = 1023;
  localparam int DEF_ADDR_W           = 10;
  localparam int DEF_DATA_W           = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/input_value_ctrl.sv
// input_value_ctrl
//   Owns the single-port input value memory and arbitrates it between a host
//   loader (writes) and a scan engine that streams every entry 0..N-1 to the
//   SNN input layer over a valid/ready handshake.
//
//   Writes are only accepted while idle, so a scan in flight always sees
//   mem_wr_en=0 and its registered read data is always fresh.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   load_valid/ready/addr/data    host write port (ready is combinational)
//   load_err                      sticky out-of-range write flag
//   scan_start                    one-cycle pulse, starts a sweep from IDLE
//   scan_busy / scan_done         sweep in progress / end-of-sweep pulse
//   out_valid/ready/addr/value    streamed (index, value) beats
//   mem_*                         single-port memory interface; read data is
//                                 registered, one cycle after the address
//
// Build option
//   INPUT_SKIP_ZERO_EN : when defined, entries holding zero are skipped and no
//                        beat is emitted for them.
module input_value_ctrl
  import input_ctrl_pkg::*;
#(
  parameter int INPUT_NEURON_NUM = DEF_INPUT_NEURON_NUM,
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int DATA_W           = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              scan_done,
  output logic              load_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_value,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr_in,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(INPUT_NEURON_NUM - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic              load_err_q, load_err_d;

  logic load_fire;
  logic load_in_range;
  logic idx_last;

  // scan_start takes priority: a load offered in the same cycle is refused.
  assign load_ready    = (state_q == IDLE) && !scan_start;
  assign load_fire     = load_valid && load_ready;
  assign load_in_range = 32'(load_addr) < 32'(INPUT_NEURON_NUM);
  // Out-of-range writes still handshake but never reach the memory.
  assign mem_wr_en     = load_fire && load_in_range;
  assign mem_addr_in   = load_addr;
  assign mem_data_in   = load_data;
  assign mem_addr_out  = idx_q;
  assign idx_last      = (idx_q == LAST_IDX);

  assign out_valid = (state_q == HOLD);
  assign scan_busy = (state_q != IDLE);
  assign scan_done = (state_q == DONE);
  assign out_addr  = out_addr_q;
  assign out_value = out_value_q;
  assign load_err  = load_err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_addr_d  = out_addr_q;
    out_value_d = out_value_q;
    load_err_d  = load_err_q;

    if (load_fire && !load_in_range) load_err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (scan_start) begin
          idx_d      = '0;
          load_err_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      // Address is already on mem_addr_out; the memory registers it here.
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
`ifdef INPUT_SKIP_ZERO_EN
        if (mem_data_out == '0) begin
          if (idx_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = ISSUE;
          end
        end else begin
          out_addr_d  = idx_q;
          out_value_d = mem_data_out;
          state_d     = HOLD;
        end
`else
        out_addr_d  = idx_q;
        out_value_d = mem_data_out;
        state_d     = HOLD;
`endif
      end
      // Beat is held stable until the consumer takes it; idx never wraps.
      HOLD: begin
        if (out_ready) begin
          if (idx_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_addr_q  <= '0;
      out_value_q <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_addr_q  <= out_addr_d;
      out_value_q <= out_value_d;
      load_err_q  <= load_err_d;
    end
  end

endmodule

// File: tb/tb_input_value_ctrl.sv
// Bench for input_value_ctrl with N=4. Holds its own single-port memory with
// registered read data and an array-based reference of what the memory should
// contain; expected beats are the non-skipped entries in index order.
module tb_input_value_ctrl;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;
`ifdef INPUT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid, load_ready;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          scan_start, scan_busy, scan_done, load_err;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_value;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr_in, mem_addr_out;
  logic [DW-1:0] mem_data_in, mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_mem [N];
  logic          err_m;

  always #5 clk = ~clk;

  input_value_ctrl #(.INPUT_NEURON_NUM(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
    .load_err(load_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_value(out_value),
    .mem_wr_en(mem_wr_en), .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out)
  );

  // Single-port memory: a write cycle does not refresh the read register.
  logic [DW-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_wr_en) mem_arr[mem_addr_in] <= mem_data_in;
    else           mem_data_out <= mem_arr[mem_addr_out];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic inr;
    inr = 32'(a) < N;
    @(negedge clk);
    load_valid = 1'b1; load_addr = a; load_data = d;
    #1;
    chk("load_ready", 32'(load_ready), 1);
    chk("load_wr_en", 32'(mem_wr_en), 32'(inr));
    if (inr) begin
      chk("load_mem_addr", 32'(mem_addr_in), 32'(a));
      chk("load_mem_data", 32'(mem_data_in), 32'(d));
      ref_mem[a] = d;
    end else begin
      err_m = 1'b1;
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    chk("load_err_after_load", 32'(load_err), 32'(err_m));
  endtask

  // mode 0: ready always high, 1: random ready, 2: 5-cycle stall at index 1
  task automatic run_scan(input int mode, input bit collide);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ev[$];
    int first_v, last_hs, done_cyc, ndone, stall_left;
    bit held, last_is_final, exp_first0, no_beats, rdy;
    logic [AW-1:0] pa;
    logic [DW-1:0] pv;
    for (int i = 0; i < N; i++)
      if (!(SKIP && ref_mem[i] == 0)) begin
        ea.push_back(AW'(i)); ev.push_back(ref_mem[i]);
      end
    no_beats      = (ea.size() == 0);
    exp_first0    = !no_beats && ea[0] == 0;
    last_is_final = !no_beats && 32'(ea[$]) == N - 1;
    first_v = -1; last_hs = -1; done_cyc = -1; ndone = 0; held = 0; stall_left = 5;
    pa = '0; pv = '0;
    @(negedge clk);
    scan_start = 1'b1; out_ready = 1'b0;
    if (collide) begin load_valid = 1'b1; load_addr = '0; load_data = 8'hAA; end
    #1;
    chk("start_load_ready", 32'(load_ready), 0);
    chk("start_busy", 32'(scan_busy), 0);
    if (collide) chk("start_wr_en", 32'(mem_wr_en), 0);
    err_m = 1'b0;
    @(negedge clk);
    scan_start = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_addr  = AW'($urandom_range(0, 7));
      load_data  = DW'($urandom);
      #1;
      chk("scan_load_ready", 32'(load_ready), 0);
      chk("scan_wr_en", 32'(mem_wr_en), 0);
      chk("scan_busy", 32'(scan_busy), 1);
      if (cyc == 1) chk("err_cleared", 32'(load_err), 0);
      if (scan_done) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
      rdy = 1'b0;
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        chk("idx_vs_out_addr", 32'(mem_addr_out), 32'(out_addr));
        if (held) begin
          chk("hold_addr", 32'(out_addr), 32'(pa));
          chk("hold_value", 32'(out_value), 32'(pv));
        end
        case (mode)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom_range(0, 1));
          default: begin
            if (out_addr == 1 && stall_left > 0) begin stall_left--; rdy = 1'b0; end
            else rdy = 1'b1;
          end
        endcase
        if (rdy) begin
          if (ea.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL extra_beat: got addr %0d value %0d, expected no beat", out_addr, out_value);
          end else begin
            chk("beat_addr", 32'(out_addr), 32'(ea[0]));
            chk("beat_value", 32'(out_value), 32'(ev[0]));
            void'(ea.pop_front()); void'(ev.pop_front());
          end
          last_hs = cyc; held = 1'b0;
        end else begin
          held = 1'b1; pa = out_addr; pv = out_value;
        end
      end
      out_ready = rdy;
      if (done_cyc >= 0) break;
      @(negedge clk);
    end
    if (done_cyc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL scan_timeout: got no scan_done, expected one within 300 cycles");
    end
    @(negedge clk);
    load_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("post_busy", 32'(scan_busy), 0);
    chk("post_done", 32'(scan_done), 0);
    chk("post_load_ready", 32'(load_ready), 1);
    chk("done_count", 32'(ndone), 1);
    chk("beats_left", 32'(ea.size()), 0);
    if (exp_first0) chk("first_latency", 32'(first_v), 3);
    if (no_beats) chk("no_beats", 32'(first_v), 32'(-1));
    if (last_is_final && done_cyc >= 0) chk("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
    if (mode == 2) chk("stall_cycles", 32'(stall_left), 0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_wr;
    logic          exp_err;
  } load_vec_t;

  initial begin
    load_vec_t tbl [6];
    bool_t_dummy();
    tbl[0] = '{4'd0, 8'd5,   1'b1, 1'b0};
    tbl[1] = '{4'd1, 8'd0,   1'b1, 1'b0};
    tbl[2] = '{4'd2, 8'd9,   1'b1, 1'b0};
    tbl[3] = '{4'd3, 8'd255, 1'b1, 1'b0};
    tbl[4] = '{4'd4, 8'h33,  1'b0, 1'b1};
    tbl[5] = '{4'd1, 8'd0,   1'b1, 1'b1};

    rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    scan_start = 1'b0; out_ready = 1'b0; err_m = 1'b0;
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_out_value", 32'(out_value), 0);
    chk("rst_busy", 32'(scan_busy), 0);
    chk("rst_done", 32'(scan_done), 0);
    chk("rst_load_err", 32'(load_err), 0);
    chk("rst_idx", 32'(mem_addr_out), 0);
    @(negedge clk); rst = 1'b0;

    // Table-driven back-to-back loads, one per cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load_valid = 1'b1; load_addr = tbl[i].addr; load_data = tbl[i].data;
      #1;
      chk("tbl_load_ready", 32'(load_ready), 1);
      chk("tbl_wr_en", 32'(mem_wr_en), 32'(tbl[i].exp_wr));
      if (32'(tbl[i].addr) < N) ref_mem[tbl[i].addr] = tbl[i].data;
      else err_m = 1'b1;
      @(posedge clk); #1;
      chk("tbl_load_err", 32'(load_err), 32'(tbl[i].exp_err));
    end
    load_valid = 1'b0;

    run_scan(0, 1'b0);   // also clears load_err
    run_scan(2, 1'b0);   // backpressure at index 1
    run_scan(0, 1'b1);   // scan_start collides with a load

    // Reset in HOLD at index 2, after making load_err sticky again.
    do_load(4'd6, 8'h11);
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (out_valid && out_addr == 2) begin found = 1'b1; out_ready = 1'b0; break; end
        out_ready = out_valid;
        @(negedge clk);
      end
      if (!found) begin
        n_tests++; n_fail++;
        $display("FAIL reach_idx2: got no beat at index 2, expected one within 40 cycles");
      end
    end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(scan_busy), 0);
    chk("midrst_done", 32'(scan_done), 0);
    chk("midrst_idx", 32'(mem_addr_out), 0);
    chk("midrst_load_err", 32'(load_err), 0);
    err_m = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("midrst_idle", 32'(load_ready), 1);
    run_scan(0, 1'b0);   // memory contents survived the reset

    // All-zero memory.
    for (int i = 0; i < N; i++) do_load(AW'(i), 8'd0);
    run_scan(0, 1'b0);

    // Randomized loads and scans against the reference array.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 8; k++)
        do_load(AW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 8'd0 : DW'($urandom));
      run_scan(1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic bool_t_dummy();
  endtask

endmodule
